// File: rtl/mux_4_to_1.sv
// ---------------------------------------------------------------------------
// mux_4_to_1
//
// Purpose:
//   WIDTH-bit, 4-input data selector used in the CPU datapath (register-file
//   read paths, ALU operand selection). The primary output is purely
//   combinational. A registered copy of the selected data, the registered
//   select, and a one-cycle select-change strobe are also provided for
//   pipelined consumers.
//
// Handshake:
//   None. There is no valid/ready protocol. Every input is taken as valid on
//   every cycle, and the registered outputs update on every rising edge.
//
// Ports (in positional order; existing positional users connect the first six):
//   in1     in  [WIDTH-1:0]  data selected when sel = 2'b00
//   in2     in  [WIDTH-1:0]  data selected when sel = 2'b01
//   in3     in  [WIDTH-1:0]  data selected when sel = 2'b10
//   in4     in  [WIDTH-1:0]  data selected when sel = 2'b11
//   sel     in  [1:0]        select code
//   out     out [WIDTH-1:0]  combinational selected data (valid during reset)
//   clk     in               rising-edge clock for the registered path
//   rst_n   in               synchronous active-low reset
//   out_r   out [WIDTH-1:0]  out, registered one cycle
//   sel_r   out [1:0]        sel, registered one cycle
//   sel_chg out              high for one cycle after sel differed from sel_r
// ---------------------------------------------------------------------------
module mux_4_to_1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out_r,
  output logic [1:0]       sel_r,
  output logic             sel_chg
);

  // Flat selection with no priority between the arms. The default arm is
  // reached only when sel carries X/Z in simulation. In that case it drives
  // all-X, so an undefined select is visible downstream. Because out is
  // assigned on every path, no latch is inferred.
  always_comb begin
    out = {WIDTH{1'bx}};
    case (sel)
      2'b00:   out = in1;
      2'b01:   out = in2;
      2'b10:   out = in3;
      2'b11:   out = in4;
      default: out = {WIDTH{1'bx}};
    endcase
  end

  // Registered path. sel_chg compares the incoming sel against the previous
  // registered value. After reset releases, that previous value is 2'b00, so
  // a nonzero first select raises the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r   <= '0;
      sel_r   <= 2'b00;
      sel_chg <= 1'b0;
    end else begin
      out_r   <= out;
      sel_r   <= sel;
      sel_chg <= (sel != sel_r);
    end
  end

endmodule

// File: tb/tb_mux_4_to_1.sv
// ---------------------------------------------------------------------------
// tb_mux_4_to_1
//
// Directed bench for mux_4_to_1. It instantiates the default 16-bit design
// and an 8-bit instance. Every expected value in this file is a hand-computed
// constant. Inputs are driven on the falling edge. Registered outputs are
// sampled 1 time unit after the rising edge, and combinational outputs are
// sampled 1 time unit after their inputs change.
// ---------------------------------------------------------------------------
module tb_mux_4_to_1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net: the directed sequence is short, so this limit should never be
  // reached.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT, WIDTH = 16 ----------------
  logic [15:0] in1, in2, in3, in4;
  logic [1:0]  sel;
  logic [15:0] out, out_r;
  logic [1:0]  sel_r;
  logic        sel_chg;

  mux_4_to_1 #(.WIDTH(16)) dut (
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .sel(sel), .out(out),
    .clk(clk), .rst_n(rst_n), .out_r(out_r), .sel_r(sel_r), .sel_chg(sel_chg)
  );

  // ---------------- DUT, WIDTH = 8 ----------------
  logic [7:0] b_in1, b_in2, b_in3, b_in4;
  logic [1:0] b_sel;
  logic [7:0] b_out, b_out_r;
  logic [1:0] b_sel_r;
  logic       b_sel_chg;

  mux_4_to_1 #(.WIDTH(8)) dut8 (
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .in4(b_in4), .sel(b_sel),
    .out(b_out), .clk(clk), .rst_n(rst_n), .out_r(b_out_r),
    .sel_r(b_sel_r), .sel_chg(b_sel_chg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Pop the next expected out_r from the queue and compare it.
  task automatic chk_q(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed empty-queue expected queued value", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, out_r, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sel(input logic [1:0] s);
    @(negedge clk);
    sel = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    in1 = 16'h1111; in2 = 16'h2222; in3 = 16'h3333; in4 = 16'h4444;
    sel = 2'b00;
    b_in1 = 8'h01; b_in2 = 8'h02; b_in3 = 8'h03; b_in4 = 8'h04;
    b_sel = 2'b00;

    // Combinational selection, stepped every 10 time units while reset is held.
    #1 chk("comb_sel00", out, 16'h1111);
    #9 sel = 2'b01;
    #1 chk("comb_sel01", out, 16'h2222);
    #9 sel = 2'b10;
    #1 chk("comb_sel10", out, 16'h3333);
    #9 sel = 2'b11;
    #1 chk("comb_sel11", out, 16'h4444);

    // Registered outputs are cleared while reset is held, and out still tracks sel.
    tick();
    tick();
    chk("rst_out_r",   out_r, 16'h0000);
    chk("rst_sel_r",   {14'd0, sel_r}, 16'd0);
    chk("rst_sel_chg", {15'd0, sel_chg}, 16'd0);
    chk("rst_out_trk", out, 16'h4444);

    // Release reset with sel = 10. The strobe fires because sel_r was 00.
    @(negedge clk);
    sel   = 2'b10;
    rst_n = 1'b1;
    tick();
    chk("rel_out_r",   out_r, 16'h3333);
    chk("rel_sel_r",   {14'd0, sel_r}, 16'h0002);
    chk("rel_sel_chg", {15'd0, sel_chg}, 16'd1);
    tick();
    chk("hold_sel_chg", {15'd0, sel_chg}, 16'd0);
    chk("hold_out_r",   out_r, 16'h3333);

    // sel = 01 held. A data change updates out at once and out_r after one edge.
    drive_sel(2'b01);
    tick();
    chk("s01_out_r",   out_r, 16'h2222);
    chk("s01_sel_chg", {15'd0, sel_chg}, 16'd1);
    tick();
    chk("s01_chg_low", {15'd0, sel_chg}, 16'd0);
    @(negedge clk);
    in2 = 16'hABCD;
    #1;
    chk("dat_comb",    out, 16'hABCD);
    chk("dat_out_r_b", out_r, 16'h2222);
    tick();
    chk("dat_out_r",   out_r, 16'hABCD);
    chk("dat_sel_chg", {15'd0, sel_chg}, 16'd0);

    // Toggle sel 00 -> 11 -> 00 on consecutive edges. The strobe stays high.
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h4444);
    exp_q.push_back(16'h1111);
    drive_sel(2'b00);
    tick();
    chk_q("tog0_out_r");
    chk("tog0_chg", {15'd0, sel_chg}, 16'd1);
    drive_sel(2'b11);
    tick();
    chk_q("tog1_out_r");
    chk("tog1_chg", {15'd0, sel_chg}, 16'd1);
    chk("tog1_sel_r", {14'd0, sel_r}, 16'h0003);
    drive_sel(2'b00);
    tick();
    chk_q("tog2_out_r");
    chk("tog2_chg", {15'd0, sel_chg}, 16'd1);
    tick();
    chk("tog3_chg", {15'd0, sel_chg}, 16'd0);

    // Reset mid-operation. Registered outputs clear, and out keeps following.
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("mid_out_r",   out_r, 16'h0000);
    chk("mid_sel_r",   {14'd0, sel_r}, 16'd0);
    chk("mid_sel_chg", {15'd0, sel_chg}, 16'd0);
    chk("mid_out",     out, 16'h1111);
    drive_sel(2'b11);
    #1 chk("mid_out_s11", out, 16'h4444);
    tick();
    chk("mid_out_r2",   out_r, 16'h0000);
    chk("mid_sel_r2",   {14'd0, sel_r}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel2_out_r",   out_r, 16'h4444);
    chk("rel2_sel_chg", {15'd0, sel_chg}, 16'd1);

    // WIDTH = 8 instance.
    b_sel = 2'b00; #1 chk("w8_sel00", {8'd0, b_out}, 16'h0001);
    b_sel = 2'b01; #1 chk("w8_sel01", {8'd0, b_out}, 16'h0002);
    b_sel = 2'b10; #1 chk("w8_sel10", {8'd0, b_out}, 16'h0003);
    b_sel = 2'b11; #1 chk("w8_sel11", {8'd0, b_out}, 16'h0004);
    tick();
    chk("w8_out_r", {8'd0, b_out_r}, 16'h0004);
    chk("w8_sel_r", {14'd0, b_sel_r}, 16'h0003);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4_to_1.md
Name: mux_4_to_1

Overview:
Parameterised 4-input, 1-output data selector for the CPU datapath (register-file read paths, ALU operand selection).
- Primary output `out` is purely combinational: zero-latency selection of one of four WIDTH-bit inputs by a 2-bit select.
- A registered copy of the selected data, the registered select, and a select-change strobe are provided for pipelined consumers.
- Instantiated as `mux_4_to_1 #(WIDTH)`.

Parameters:
- WIDTH, 16, bit width of every data input and of both data outputs.

Ports:
- clk  input  1  system clock; all registered state updates on its rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk.
- in1  input  WIDTH  data selected when sel = 2'b00.
- in2  input  WIDTH  data selected when sel = 2'b01.
- in3  input  WIDTH  data selected when sel = 2'b10.
- in4  input  WIDTH  data selected when sel = 2'b11.
- sel  input  2  select code.
- out  output  WIDTH  combinational selected data.
- out_r  output  WIDTH  selected data registered one cycle.
- sel_r  output  2  sel registered one cycle.
- sel_chg  output  1  registered strobe: high for one cycle after sel differs from sel_r.

Behaviour:
- Port order for positional instantiation: in1, in2, in3, in4, sel, out, clk, rst_n, out_r, sel_r, sel_chg. Existing positional users connect the first six ports.
- Select mapping:
  - out = in1 when sel=00.
  - out = in2 when sel=01.
  - out = in3 when sel=10.
  - out = in4 when sel=11.
  - Full case; no priority logic.
- out is combinational:
  - Changes in the same delta as any input or sel change.
  - Independent of clk and rst_n; valid during reset.
- sel containing X/Z: out drives all-X (simulation only; no latch inferred).
- Registered path, at each rising clk:
  - rst_n=0: out_r <= 0, sel_r <= 2'b00, sel_chg <= 0.
  - otherwise: out_r <= out, sel_r <= sel, sel_chg <= (sel != sel_r).
- Latency: out 0 cycles; out_r and sel_r 1 cycle.
- sel_chg asserts for exactly one cycle per select change. It stays high on consecutive cycles if sel changes every cycle.
- Data changes with a constant sel update out_r but do not assert sel_chg.
- Reset mid-operation: registered outputs clear on the next rising edge with rst_n low and stay cleared while rst_n is low. out continues to follow the inputs.
- First cycle after reset release: sel_chg compares against sel_r=00, so a nonzero sel raises sel_chg.
- No arithmetic, no width conversion: every bit passes through unchanged; WIDTH >= 1.

Test Plan:
- Bench drives in1=16'h1111, in2=16'h2222, in3=16'h3333, in4=16'h4444.
- sel stepped 00, 01, 10, 11 every 10 time units -> out = 1111, 2222, 3333, 4444 respectively, with no clock dependency.
- Hold rst_n=0 for 2 clocks -> out_r = 0000, sel_r = 00, sel_chg = 0, while out still tracks sel.
- Release reset with sel=10 -> next edge: out_r = 3333, sel_r = 10, sel_chg = 1; following edge with sel held: sel_chg = 0.
- With sel=01 held, change in2 from 2222 to ABCD -> out = ABCD immediately, out_r = ABCD after one edge, sel_chg stays 0.
- Toggle sel 00 -> 11 -> 00 on consecutive edges -> sel_chg high for both cycles; out_r = 1111, 4444, 1111.
- WIDTH=8 instance with in1..in4 = 01, 02, 03, 04 -> out matches per sel, upper bits absent.
